// File: rtl/star_scanner_if.sv
// Bus between the star scanner and its neighbours: frame-memory read port
// plus the found-coordinate handshake toward the master FSM.
//
// Memory read: the scanner raises mem_rd with the address on mem_x/mem_y;
// the memory returns mem_col exactly one cycle later.
// Found handshake: found_valid/found_x/found_y are held stable by the
// scanner until the consumer raises found_ack at a clock edge. The transfer
// completes on that edge. found_ack outside a pending report has no effect.
//
// master : the scanner (drives addresses and found_*).
// slave  : frame memory + consumer (drives mem_col and found_ack).
interface star_scanner_if #(
  parameter int XSZ   = 8,
  parameter int YSZ   = 7,
  parameter int COLSZ = 3
);
  logic             mem_rd;
  logic [XSZ-1:0]   mem_x;
  logic [YSZ-1:0]   mem_y;
  logic [COLSZ-1:0] mem_col;
  logic             found_valid;
  logic [XSZ-1:0]   found_x;
  logic [YSZ-1:0]   found_y;
  logic             found_ack;

  modport master (
    output mem_rd, mem_x, mem_y, found_valid, found_x, found_y,
    input  mem_col, found_ack
  );

  modport slave (
    input  mem_rd, mem_x, mem_y, found_valid, found_x, found_y,
    output mem_col, found_ack
  );
endinterface

// File: rtl/star_scanner.sv
// star_scanner: raster-scans the XMAX x YMAX frame memory one pixel per
// cycle and reports every pixel whose colour equals STAR_COL through the
// found_valid/found_ack handshake, then resumes from the following pixel.
//
// Ports:
//   clk, resetn   single clock, asynchronous active-low reset
//   start         level; starts a scan when sampled high in IDLE
//   bus           star_scanner_if.master (memory read port + found handshake)
//   busy          high in SCAN and HIT
//   done          high in DONE (whole frame scanned)
//   box_load, box_xl/xr/yt/yb  exclusion box (only with STAR_SCAN_SKIP_BOX_EN)
//   scan_state    current FSM state, for debug / checkers
//
// Build option: define STAR_SCAN_SKIP_BOX_EN to suppress reports from
// pixels inside a loaded exclusion box. Without it the box ports are unused.
module star_scanner #(
  parameter int               XSZ      = 8,
  parameter int               YSZ      = 7,
  parameter int               COLSZ    = 3,
  parameter int               XMAX     = 160,
  parameter int               YMAX     = 120,
  parameter logic [COLSZ-1:0] STAR_COL = {COLSZ{1'b1}}
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  star_scanner_if.master     bus,
  output logic               busy,
  output logic               done,
  input  logic               box_load,
  input  logic [XSZ-1:0]     box_xl,
  input  logic [XSZ-1:0]     box_xr,
  input  logic [YSZ-1:0]     box_yt,
  input  logic [YSZ-1:0]     box_yb,
  output logic [1:0]         scan_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XSZ-1:0] X_LAST = XSZ'(XMAX - 1);
  localparam logic [YSZ-1:0] Y_LAST = YSZ'(YMAX - 1);

  logic [1:0]     state;
  logic [XSZ-1:0] ptr_x, ptr_nx_x, p_x, p_nx_x;
  logic [YSZ-1:0] ptr_y, ptr_nx_y, p_y, p_nx_y;
  logic           ptr_last, p_last, found_last;
  logic           scan_end;   // read of the last pixel has been issued
  logic           p_v;        // p_x/p_y hold the address whose data is on mem_col
  logic           hit;

  // Next pixel in raster order, modulo the frame (not modulo 2^XSZ).
  always_comb begin
    ptr_nx_x = ptr_x + 1'b1;
    ptr_nx_y = ptr_y;
    if (ptr_x == X_LAST) begin
      ptr_nx_x = '0;
      ptr_nx_y = (ptr_y == Y_LAST) ? '0 : ptr_y + 1'b1;
    end
    p_nx_x = p_x + 1'b1;
    p_nx_y = p_y;
    if (p_x == X_LAST) begin
      p_nx_x = '0;
      p_nx_y = (p_y == Y_LAST) ? '0 : p_y + 1'b1;
    end
  end

  assign ptr_last   = (ptr_x == X_LAST) && (ptr_y == Y_LAST);
  assign p_last     = (p_x == X_LAST) && (p_y == Y_LAST);
  assign found_last = (bus.found_x == X_LAST) && (bus.found_y == Y_LAST);

`ifdef STAR_SCAN_SKIP_BOX_EN
  logic           box_v;
  logic [XSZ-1:0] bx_l, bx_r;
  logic [YSZ-1:0] by_t, by_b;
  logic           in_box;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      box_v <= 1'b0;
      bx_l  <= '0;
      bx_r  <= '0;
      by_t  <= '0;
      by_b  <= '0;
    end else if (box_load) begin
      box_v <= 1'b1;
      bx_l  <= box_xl;
      bx_r  <= box_xr;
      by_t  <= box_yt;
      by_b  <= box_yb;
    end
  end

  assign in_box = box_v && (p_x >= bx_l) && (p_x <= bx_r) &&
                  (p_y >= by_t) && (p_y <= by_b);
  assign hit    = p_v && (bus.mem_col == STAR_COL) && !in_box;
`else
  logic unused_box;
  assign unused_box = ^{box_load, box_xl, box_xr, box_yt, box_yb};
  assign hit        = p_v && (bus.mem_col == STAR_COL);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      ptr_x           <= '0;
      ptr_y           <= '0;
      scan_end        <= 1'b0;
      p_x             <= '0;
      p_y             <= '0;
      p_v             <= 1'b0;
      bus.mem_rd      <= 1'b0;
      bus.mem_x       <= '0;
      bus.mem_y       <= '0;
      bus.found_valid <= 1'b0;
      bus.found_x     <= '0;
      bus.found_y     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.mem_rd      <= 1'b0;
          bus.found_valid <= 1'b0;
          p_v             <= 1'b0;
          if (start) begin
            state    <= S_SCAN;
            ptr_x    <= '0;
            ptr_y    <= '0;
            scan_end <= 1'b0;
          end
        end
        S_SCAN: begin
          bus.found_valid <= 1'b0;
          if (hit) begin
            // The read issued after the hit is dropped (p_v cleared) and the
            // pointer rewinds so that pixel is read again on resume.
            state           <= S_HIT;
            bus.found_valid <= 1'b1;
            bus.found_x     <= p_x;
            bus.found_y     <= p_y;
            bus.mem_rd      <= 1'b0;
            p_v             <= 1'b0;
            ptr_x           <= p_nx_x;
            ptr_y           <= p_nx_y;
            scan_end        <= 1'b0;
          end else if (p_v && p_last) begin
            state      <= S_DONE;
            bus.mem_rd <= 1'b0;
            p_v        <= 1'b0;
          end else begin
            p_x <= bus.mem_x;
            p_y <= bus.mem_y;
            p_v <= bus.mem_rd;
            if (!scan_end) begin
              bus.mem_rd <= 1'b1;
              bus.mem_x  <= ptr_x;
              bus.mem_y  <= ptr_y;
              ptr_x      <= ptr_nx_x;
              ptr_y      <= ptr_nx_y;
              scan_end   <= ptr_last;
            end else begin
              bus.mem_rd <= 1'b0;
            end
          end
        end
        S_HIT: begin
          bus.mem_rd <= 1'b0;
          p_v        <= 1'b0;
          if (bus.found_ack) begin
            state <= found_last ? S_DONE : S_SCAN;
          end
        end
        default: begin  // S_DONE
          bus.mem_rd      <= 1'b0;
          bus.found_valid <= 1'b0;
          p_v             <= 1'b0;
          if (!start) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy       = (state == S_SCAN) || (state == S_HIT);
  assign done       = (state == S_DONE);
  assign scan_state = state;

endmodule

// File: tb/tb_star_scanner.sv
module tb_star_scanner;
  localparam int XMAX = 160;
  localparam int YMAX = 120;
  localparam int NPIX = XMAX * YMAX;
  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       busy, done;
  logic       box_load;
  logic [7:0] box_xl, box_xr;
  logic [6:0] box_yt, box_yb;
  logic [1:0] scan_state;

  star_scanner_if bus ();

  star_scanner dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .box_load   (box_load),
    .box_xl     (box_xl),
    .box_xr     (box_xr),
    .box_yt     (box_yt),
    .box_yb     (box_yb),
    .scan_state (scan_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;    // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- frame memory model (1-cycle read latency) ----------------
  logic [2:0] frame [NPIX];
  always @(posedge clk) begin
    if (bus.mem_rd && bus.mem_x < XMAX && bus.mem_y < YMAX)
      bus.mem_col <= frame[int'(bus.mem_y) * XMAX + int'(bus.mem_x)];
  end

  // ---------------- read monitor ----------------
  // Runs on the edge after a read is registered, so it logs the edge that
  // registered it (the old cyc value).
  int rd_count, first_rd_edge, last_rd_edge, oob_count;
  logic [7:0] first_rd_x;
  logic [6:0] first_rd_y;
  int rd_edge [NPIX];
  always @(posedge clk) begin
    if (resetn && bus.mem_rd) begin
      if (bus.mem_x >= XMAX || bus.mem_y >= YMAX) oob_count++;
      else rd_edge[int'(bus.mem_y) * XMAX + int'(bus.mem_x)] = cyc;
      if (rd_count == 0) begin
        first_rd_edge = cyc;
        first_rd_x    = bus.mem_x;
        first_rd_y    = bus.mem_y;
      end
      rd_count++;
      last_rd_edge = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q [$];   // {y, x}

  function automatic logic [14:0] xy(input int x, input int y);
    return {7'(y), 8'(x)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    rd_count = 0; oob_count = 0; first_rd_edge = -1; last_rd_edge = -1;
  endtask

  task automatic fill_bg();
    for (int i = 0; i < NPIX; i++) frame[i] = 3'($urandom_range(0, 6));
  endtask

  task automatic put_star(input int x, input int y);
    frame[y * XMAX + x] = 3'b111;
  endtask

  task automatic do_reset();
    resetn = 1'b0; start = 1'b0; bus.found_ack = 1'b0; box_load = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.found_ack = 1'b1;
    tick();
    bus.found_ack = 1'b0;
    tick();
  endtask

  task automatic wait_event(input int limit, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (!(bus.found_valid || done)) begin
      if (n >= limit) begin
        timed_out = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; bus.found_ack = 1'b0; box_load = 1'b0;
    box_xl = '0; box_xr = '0; box_yt = '0; box_yb = '0;
    clear_mon();
    repeat (3) tick();
    checks++;
    if ({bus.mem_rd, bus.found_valid, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rd/fv/busy/done=%b want 0000",
               {bus.mem_rd, bus.found_valid, busy, done});
    end
    checks++;
    if ({bus.mem_x, bus.mem_y, bus.found_x, bus.found_y} !== 30'd0) begin
      failures++;
      $display("FAIL reset_coords got mem=(%0d,%0d) found=(%0d,%0d) want zeros",
               bus.mem_x, bus.mem_y, bus.found_x, bus.found_y);
    end
    resetn = 1'b1;
    repeat (3) tick();
    checks++;
    if (scan_state !== 2'd0 || busy !== 1'b0 || rd_count !== 0) begin
      failures++;
      $display("FAIL reset_idle got state=%0d busy=%b reads=%0d want 0/0/0",
               scan_state, busy, rd_count);
    end
  endtask

  task automatic test_no_star();
    bit to;
    int k, reads_at_done, done_edge;
    fill_bg();
    clear_mon();
    k = cyc;
    start = 1'b1;
    tick();
    wait_event(LIMIT, to);
    done_edge = cyc;
    checks++;
    if (to || bus.found_valid !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL nostar_end got timeout=%0d fv=%b done=%b want 0/0/1",
               to, bus.found_valid, done);
    end
    checks++;
    if (rd_count !== NPIX || last_rd_edge - first_rd_edge + 1 !== NPIX) begin
      failures++;
      $display("FAIL nostar_reads got count=%0d span=%0d want %0d consecutive",
               rd_count, last_rd_edge - first_rd_edge + 1, NPIX);
    end
    checks++;
    if (first_rd_edge !== k + 2 || first_rd_x !== 8'd0 || first_rd_y !== 7'd0) begin
      failures++;
      $display("FAIL nostar_first got edge=%0d (%0d,%0d) want edge=%0d (0,0)",
               first_rd_edge, first_rd_x, first_rd_y, k + 2);
    end
    checks++;
    if (done_edge - last_rd_edge !== 2) begin
      failures++;
      $display("FAIL nostar_done_lat got %0d edges want 2", done_edge - last_rd_edge);
    end
    checks++;
    if (oob_count !== 0) begin
      failures++;
      $display("FAIL nostar_bounds got %0d out-of-frame reads want 0", oob_count);
    end
    // start still high: must stay in DONE with no new reads
    reads_at_done = rd_count;
    repeat (3) tick();
    checks++;
    if (done !== 1'b1 || rd_count !== reads_at_done) begin
      failures++;
      $display("FAIL nostar_hold_done got done=%b extra_reads=%0d want 1/0",
               done, rd_count - reads_at_done);
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || scan_state !== 2'd0) begin
      failures++;
      $display("FAIL nostar_rearm got done=%b busy=%b state=%0d want 0/0/0",
               done, busy, scan_state);
    end
  endtask

  task automatic test_hold_and_resume();
    bit to;
    int hold_bad;
    logic [14:0] e;
    do_reset();
    fill_bg();
    put_star(5, 2);
    exp_q.push_back(xy(5, 2));
    clear_mon();
    start_pulse();
    wait_event(LIMIT, to);
    checks++;
    if (to || bus.found_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL hold_found got timeout=%0d fv=%b want found", to, bus.found_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.found_y, bus.found_x} !== e) begin
        failures++;
        $display("FAIL hold_coords got (%0d,%0d) want (%0d,%0d)",
                 bus.found_x, bus.found_y, e[7:0], e[14:8]);
      end
      checks++;
      if (cyc - rd_edge[2 * XMAX + 5] !== 2) begin
        failures++;
        $display("FAIL hold_latency got %0d edges want 2", cyc - rd_edge[2 * XMAX + 5]);
      end
    end
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.found_valid !== 1'b1 || bus.found_x !== 8'd5 || bus.found_y !== 7'd2 ||
          bus.mem_rd !== 1'b0 || busy !== 1'b1)
        hold_bad++;
    end
    checks++;
    if (hold_bad !== 0) begin
      failures++;
      $display("FAIL hold_stable got %0d bad cycles want 0", hold_bad);
    end
    ack_pulse();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_x !== 8'd6 || bus.mem_y !== 7'd2 ||
        bus.found_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_resume got rd=%b (%0d,%0d) fv=%b want 1 (6,2) 0",
               bus.mem_rd, bus.mem_x, bus.mem_y, bus.found_valid);
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [14:0] e;
    do_reset();
    fill_bg();
    put_star(159, 0);
    put_star(0, 1);
    exp_q.push_back(xy(159, 0));
    exp_q.push_back(xy(0, 1));
    clear_mon();
    start_pulse();
    for (int h = 0; h < 2; h++) begin
      wait_event(LIMIT, to);
      checks++;
      if (to || bus.found_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL wrap_found%0d got timeout=%0d fv=%b done=%b want found",
                 h, to, bus.found_valid, done);
        break;
      end
      e = exp_q.pop_front();
      checks++;
      if ({bus.found_y, bus.found_x} !== e) begin
        failures++;
        $display("FAIL wrap_coords%0d got (%0d,%0d) want (%0d,%0d)",
                 h, bus.found_x, bus.found_y, e[7:0], e[14:8]);
      end
      ack_pulse();
      if (h == 0) begin
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_x !== 8'd0 || bus.mem_y !== 7'd1) begin
          failures++;
          $display("FAIL wrap_resume got rd=%b (%0d,%0d) want 1 (0,1)",
                   bus.mem_rd, bus.mem_x, bus.mem_y);
        end
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL wrap_queue got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_last_pixel();
    bit to;
    int reads_at_ack, late_bad;
    logic [14:0] e;
    do_reset();
    fill_bg();
    put_star(159, 119);
    exp_q.push_back(xy(159, 119));
    clear_mon();
    start_pulse();
    wait_event(LIMIT, to);
    checks++;
    if (to || bus.found_valid !== 1'b1) begin
      failures++;
      $display("FAIL last_found got timeout=%0d fv=%b done=%b want found",
               to, bus.found_valid, done);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.found_y, bus.found_x} !== e) begin
        failures++;
        $display("FAIL last_coords got (%0d,%0d) want (159,119)", bus.found_x, bus.found_y);
      end
    end
    exp_q.delete();
    reads_at_ack = rd_count;
    bus.found_ack = 1'b1;
    tick();
    bus.found_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL last_done got done=%b busy=%b want 1/0", done, busy);
    end
    late_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_rd !== 1'b0 || bus.found_valid !== 1'b0) late_bad++;
    end
    checks++;
    if (late_bad !== 0 || rd_count !== reads_at_ack) begin
      failures++;
      $display("FAIL last_quiet got bad=%0d extra_reads=%0d want 0/0",
               late_bad, rd_count - reads_at_ack);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int quiet_bad;
    do_reset();
    fill_bg();
    put_star(3, 0);
    clear_mon();
    start_pulse();
    wait_event(LIMIT, to);
    resetn = 1'b0;
    #1;
    checks++;
    if (to || {bus.mem_rd, bus.found_valid, busy, done} !== 4'b0 ||
        {bus.found_x, bus.found_y, bus.mem_x, bus.mem_y} !== 30'd0) begin
      failures++;
      $display("FAIL reset_hit got timeout=%0d rd/fv/busy/done=%b found=(%0d,%0d) want all 0",
               to, {bus.mem_rd, bus.found_valid, busy, done}, bus.found_x, bus.found_y);
    end
    tick();
    resetn = 1'b1;
    tick();
    start_pulse();
    repeat (50) tick();
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd, busy, done} !== 3'b0 || {bus.mem_x, bus.mem_y} !== 15'd0) begin
      failures++;
      $display("FAIL reset_scan got rd/busy/done=%b mem=(%0d,%0d) want 0 (0,0)",
               {bus.mem_rd, busy, done}, bus.mem_x, bus.mem_y);
    end
    tick();
    resetn = 1'b1;
    quiet_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_rd !== 1'b0 || bus.found_valid !== 1'b0 || busy !== 1'b0) quiet_bad++;
    end
    checks++;
    if (quiet_bad !== 0) begin
      failures++;
      $display("FAIL reset_quiet got %0d active cycles want 0", quiet_bad);
    end
  endtask

  task automatic test_box();
    bit to;
    logic [14:0] e;
    do_reset();
    fill_bg();
    put_star(5, 2);
    put_star(20, 2);
    box_xl = 8'd4; box_xr = 8'd8; box_yt = 7'd1; box_yb = 7'd3;
    box_load = 1'b1;
    tick();
    box_load = 1'b0;
`ifdef STAR_SCAN_SKIP_BOX_EN
    exp_q.push_back(xy(20, 2));
`else
    exp_q.push_back(xy(5, 2));
    exp_q.push_back(xy(20, 2));
`endif
    clear_mon();
    start_pulse();
    while (exp_q.size() != 0) begin
      wait_event(LIMIT, to);
      checks++;
      if (to || bus.found_valid !== 1'b1) begin
        failures++;
        $display("FAIL box_found got timeout=%0d fv=%b done=%b want found",
                 to, bus.found_valid, done);
        break;
      end
      e = exp_q.pop_front();
      checks++;
      if ({bus.found_y, bus.found_x} !== e) begin
        failures++;
        $display("FAIL box_coords got (%0d,%0d) want (%0d,%0d)",
                 bus.found_x, bus.found_y, e[7:0], e[14:8]);
      end
      ack_pulse();
    end
    exp_q.delete();
    do_reset();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_no_star();
    test_hold_and_resume();
    test_wrap();
    test_last_pixel();
    test_reset_mid();
    test_box();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
